// File: rtl/seg7_scan_ctrl.sv
// seg7_scan_ctrl -- time-multiplexed scan controller for an 8-digit
// seven-segment display with a double-buffered frame.
//
// Writers fill the shadow frame (wr_en/wr_addr/wr_data) and request a
// publish with commit. The shadow is copied to the active frame only at
// the 7 -> 0 scan wrap, so a frame is never shown half-old, half-new.
//
// Ports:
//   clk, rst        clock, asynchronous active-high reset
//   wr_en/wr_addr/wr_data  shadow digit write ({blank, hex[3:0]})
//   dp_mask         decimal point per digit, sampled live each slot
//   commit          one-cycle publish request
//   pending         commit accepted, swap not yet done
//   commit_ack      high during the swap cycle
//   seg_out0        segments for digits 0-3, {a,b,c,d,e,f,g,dp}
//   seg_out1        segments for digits 4-7, same encoding
//   seg_en          one-hot digit enable
//   blink_mask      (only with SEG7_BLINK_EN) digits that blink
//
// Optional feature macro: SEG7_BLINK_EN.

module seg7_scan_ctrl #(
    parameter int SCAN_DIV    = 100000,
    parameter int BLINK_TICKS = 250
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       wr_en,
    input  logic [2:0] wr_addr,
    input  logic [4:0] wr_data,
    input  logic [7:0] dp_mask,
    input  logic       commit,
`ifdef SEG7_BLINK_EN
    input  logic [7:0] blink_mask,
`endif
    output logic       pending,
    output logic       commit_ack,
    output logic [7:0] seg_out0,
    output logic [7:0] seg_out1,
    output logic [7:0] seg_en
);

    localparam int CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [4:0] BLANK = 5'h10;

    logic [CW-1:0]      cnt;
    logic [2:0]         idx;
    logic [7:0][4:0]    shadow;
    logic [7:0][4:0]    active;

    logic               tick;
    logic               swap;
    logic [2:0]         nidx;
    logic [4:0]         src;
    logic [7:0]         pattern;

    function automatic logic [6:0] decode(input logic [3:0] h);
        case (h)
            4'h0: decode = 7'b1111110;
            4'h1: decode = 7'b0110000;
            4'h2: decode = 7'b1101101;
            4'h3: decode = 7'b1111001;
            4'h4: decode = 7'b0110011;
            4'h5: decode = 7'b1011011;
            4'h6: decode = 7'b1011111;
            4'h7: decode = 7'b1110000;
            4'h8: decode = 7'b1111111;
            4'h9: decode = 7'b1111011;
            4'hA: decode = 7'b1110111;
            4'hB: decode = 7'b0011111;
            4'hC: decode = 7'b1001110;
            4'hD: decode = 7'b0111101;
            4'hE: decode = 7'b1001111;
            default: decode = 7'b1000111;
        endcase
    endfunction

`ifdef SEG7_BLINK_EN
    localparam int BW = (BLINK_TICKS > 1) ? $clog2(BLINK_TICKS) : 1;
    logic [BW-1:0] bcnt;
    logic          phase;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bcnt  <= '0;
            phase <= 1'b1;
        end else if (tick) begin
            if (bcnt == BW'(BLINK_TICKS - 1)) begin
                bcnt  <= '0;
                phase <= ~phase;
            end else begin
                bcnt <= bcnt + 1'b1;
            end
        end
    end
`endif

    assign tick       = (cnt == CW'(SCAN_DIV - 1));
    assign swap       = tick && (idx == 3'd7) && pending;
    assign commit_ack = swap;
    assign nidx       = idx + 3'd1;

    // On the swap tick the new frame's digit 0 comes straight from the
    // shadow, since active is only updated at that same edge.
    always_comb begin
        src     = swap ? shadow[0] : active[nidx];
        pattern = src[4] ? 8'h00 : {decode(src[3:0]), dp_mask[nidx]};
`ifdef SEG7_BLINK_EN
        if (!phase && blink_mask[nidx])
            pattern = 8'h00;
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt      <= '0;
            idx      <= 3'd7;
            pending  <= 1'b0;
            seg_en   <= 8'h00;
            seg_out0 <= 8'h00;
            seg_out1 <= 8'h00;
            for (int i = 0; i < 8; i++) begin
                shadow[i] <= BLANK;
                active[i] <= BLANK;
            end
        end else begin
            cnt <= tick ? '0 : cnt + 1'b1;

            if (tick) begin
                idx      <= nidx;
                seg_en   <= 8'h01 << nidx;
                seg_out0 <= nidx[2] ? 8'h00 : pattern;
                seg_out1 <= nidx[2] ? pattern : 8'h00;
            end

            // Copy reads the pre-write shadow; a same-cycle write lands after.
            if (swap) begin
                active  <= shadow;
                pending <= commit;
            end else if (commit) begin
                pending <= 1'b1;
            end

            if (wr_en)
                shadow[wr_addr] <= wr_data;
        end
    end

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Directed bench for seg7_scan_ctrl with SCAN_DIV=4. After reset release
// the slot for digit k of frame f is shown after posedge 4*(8f+k+1).
module tb_seg7_scan_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       wr_en = 1'b0;
    logic [2:0] wr_addr = '0;
    logic [4:0] wr_data = '0;
    logic [7:0] dp_mask = '0;
    logic       commit = 1'b0;
    logic       pending, commit_ack;
    logic [7:0] seg_out0, seg_out1, seg_en;

    int tests = 0;
    int fails = 0;
    int ack_cnt = 0;
    int ack_base;

    always #5 clk = ~clk;

    seg7_scan_ctrl #(.SCAN_DIV(4), .BLINK_TICKS(2)) dut (
        .clk(clk), .rst(rst),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .dp_mask(dp_mask), .commit(commit),
`ifdef SEG7_BLINK_EN
        .blink_mask(8'h00),
`endif
        .pending(pending), .commit_ack(commit_ack),
        .seg_out0(seg_out0), .seg_out1(seg_out1), .seg_en(seg_en)
    );

    always @(posedge clk or posedge rst)
        if (rst) ack_cnt <= 0;
        else if (commit_ack) ack_cnt <= ack_cnt + 1;

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic wr(input logic [2:0] a, input logic [4:0] d);
        wr_en = 1'b1; wr_addr = a; wr_data = d;
        cyc(1);
        wr_en = 1'b0;
    endtask

    task automatic pulse_commit();
        commit = 1'b1;
        cyc(1);
        commit = 1'b0;
    endtask

    logic [7:0] exp_seg [8] = '{8'h60, 8'hDA, 8'hF2, 8'h66, 8'hB6, 8'hBE, 8'hE0, 8'hFE};
    logic [7:0] one_hot;

    initial begin
        #1;
        chk("rst_seg_en", seg_en, 8'h00);
        chk("rst_pending", {7'd0, pending}, 8'h00);
        @(negedge clk); @(negedge clk);
        rst = 1'b0;                                   // P=0

        cyc(3);                                       // P=3
        chk("dark_seg_en", seg_en, 8'h00);
        chk("dark_seg0", seg_out0, 8'h00);
        cyc(1);                                       // P=4 digit 0
        chk("first_seg_en", seg_en, 8'h01);
        chk("first_seg0_blank", seg_out0, 8'h00);
        for (int i = 1; i <= 8; i++) begin
            cyc(4);
            one_hot = 8'h01 << (i % 8);
            chk("scan_seg_en", seg_en, one_hot);
            chk("scan_blank", seg_out0 | seg_out1, 8'h00);
        end                                           // P=36 digit 0

        // Load 1..8 and commit mid-frame
        ack_base = ack_cnt;
        for (int i = 0; i < 8; i++) wr(3'(i), 5'(i + 1)); // P=44
        pulse_commit();                               // P=45
        chk("commit_pending", {7'd0, pending}, 8'h01);
        chk("old_frame_en", seg_en, 8'h04);
        chk("old_frame_blank", seg_out0, 8'h00);
        cyc(22);                                      // P=67 swap cycle
        chk("swap_ack", {7'd0, commit_ack}, 8'h01);
        cyc(1);                                       // P=68
        chk("post_swap_pending", {7'd0, pending}, 8'h00);
        chk("post_swap_ack", {7'd0, commit_ack}, 8'h00);
        chk("new_d0_en", seg_en, 8'h01);
        chk("new_d0", seg_out0, exp_seg[0]);
        chk("new_d0_bus1", seg_out1, 8'h00);
        for (int k = 1; k < 8; k++) begin
            cyc(4);
            chk("new_frame", (k < 4) ? seg_out0 : seg_out1, exp_seg[k]);
            chk("idle_bus", (k < 4) ? seg_out1 : seg_out0, 8'h00);
        end                                           // P=96
        chk("one_ack", 8'(ack_cnt - ack_base), 8'h01);

        // Two commits in one frame -> single ack
        ack_base = ack_cnt;
        cyc(4);                                       // P=100 digit 0
        pulse_commit();                               // P=101
        cyc(5);                                       // P=106
        pulse_commit();                               // P=107
        chk("dbl_pending", {7'd0, pending}, 8'h01);
        cyc(24);                                      // P=131 swap cycle
        chk("dbl_swap_ack", {7'd0, commit_ack}, 8'h01);
        cyc(1);                                       // P=132
        chk("dbl_pending_clr", {7'd0, pending}, 8'h00);
        chk("dbl_one_ack", 8'(ack_cnt - ack_base), 8'h01);
        chk("dbl_d0", seg_out0, 8'h60);

        // Write on the swap cycle goes to the next frame
        pulse_commit();                               // P=133
        cyc(30);                                      // P=163 swap cycle
        chk("wswap_ack", {7'd0, commit_ack}, 8'h01);
        wr(3'd3, 5'h09);                              // P=164
        cyc(12);                                      // P=176 digit 3
        chk("wswap_d3_en", seg_en, 8'h08);
        chk("wswap_d3_old", seg_out0, 8'h66);
        pulse_commit();                               // P=177
        cyc(19);                                      // P=196 digit 0
        chk("wswap_d0", seg_out0, 8'h60);
        cyc(12);                                      // P=208 digit 3
        chk("wswap_d3_new", seg_out0, 8'hF6);

        // Decimal point and blank override
        dp_mask = 8'h01;
        wr(3'd0, 5'h00);                              // P=209
        pulse_commit();                               // P=210
        cyc(18);                                      // P=228 digit 0
        chk("dp_d0", seg_out0, 8'hFD);
        wr(3'd0, 5'h10);                              // P=229
        pulse_commit();                               // P=230
        cyc(30);                                      // P=260 digit 0
        chk("blank_dp", seg_out0, 8'h00);
        chk("blank_dp_en", seg_en, 8'h01);
        cyc(4);                                       // P=264 digit 1
        chk("dp_off_d1", seg_out0, 8'hDA);

        // Reset mid-frame drops pending commit and darkens display
        pulse_commit();
        chk("pre_rst_pending", {7'd0, pending}, 8'h01);
        rst = 1'b1;
        #1;
        chk("rst_mid_en", seg_en, 8'h00);
        chk("rst_mid_seg0", seg_out0, 8'h00);
        chk("rst_mid_pending", {7'd0, pending}, 8'h00);
        @(negedge clk);
        rst = 1'b0;
        cyc(3);
        chk("rst2_dark", seg_en, 8'h00);
        cyc(1);
        chk("rst2_en", seg_en, 8'h01);
        chk("rst2_blank", seg_out0, 8'h00);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
